edc_mem_ctrl: RTL and testbench

- Parametrised ECC-protected memory controller on the Wishbone data path; successor to the fixed 128-bit combinational EDC memory.
- Owns a data array and a check array, and splits each access into 32-bit lanes, each protected by SEC-DED.
- Sequential behaviour:
  - registered reads;
  - read-modify-write for partial-lane writes;
  - optional corrected-data writeback;
  - error counters, sticky status and test error injection.

---
 rtl/edc_pkg.sv | 46 ++++
 rtl/edc_lane.sv | 34 +++
 rtl/edc_mem_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_edc_mem_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/edc_pkg.sv
// Shared constants, FSM encoding and the SEC-DED code used by edc_mem_ctrl.
// Hamming(38,32): check bits sit at the power-of-two codeword positions, data bits fill the rest.
package edc_pkg;

    localparam int LANE_WIDTH = 32;
    localparam int ECC_WIDTH  = 8;
    localparam int LANE_BYTES = LANE_WIDTH / 8;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WACK  = 3'd1;
    localparam logic [2:0] ST_READ  = 3'd2;
    localparam logic [2:0] ST_RESP  = 3'd3;
    localparam logic [2:0] ST_MERGE = 3'd4;

    // Codeword position (3..38, skipping powers of two) of data bit i.
    function automatic logic [5:0] edc_pos(input int i);
        int         n;
        logic [5:0] r;
        n = 0;
        r = '0;
        for (int p = 3; p < 39; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (n == i) r = 6'(p);
                n++;
            end
        end
        return r;
    endfunction

    function automatic logic [5:0] edc_syn(input logic [LANE_WIDTH-1:0] d);
        logic [5:0] s;
        s = '0;
        for (int i = 0; i < LANE_WIDTH; i++) begin
            if (d[i]) s ^= edc_pos(i);
        end
        return s;
    endfunction

    // {0, overall parity, Hamming check bits}; all-zero data encodes to all-zero check bits.
    function automatic logic [ECC_WIDTH-1:0] edc_encode(input logic [LANE_WIDTH-1:0] d);
        logic [5:0] c;
        c = edc_syn(d);
        return {1'b0, (^d) ^ (^c), c};
    endfunction

endpackage

// File: rtl/edc_lane.sv
// One 32-bit SEC-DED lane: encodes write data and decodes/corrects one stored lane.
module edc_lane
    import edc_pkg::*;
(
    input  logic [LANE_WIDTH-1:0] enc_data_i,
    output logic [ECC_WIDTH-1:0]  enc_chk_o,
    input  logic [LANE_WIDTH-1:0] dec_data_i,
    input  logic [ECC_WIDTH-1:0]  dec_chk_i,
    output logic [LANE_WIDTH-1:0] dec_data_o,
    output logic                  dec_corr_o,
    output logic                  dec_uncorr_o
);

    logic [5:0] syn;
    logic       par_err;
    logic       unused_chk_msb;

    assign enc_chk_o      = edc_encode(enc_data_i);
    assign unused_chk_msb = dec_chk_i[ECC_WIDTH-1];

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        syn        = edc_syn(dec_data_i) ^ dec_chk_i[5:0];
        par_err    = (^dec_data_i) ^ (^dec_chk_i[6:0]);
        dec_data_o = dec_data_i;
        // A syndrome pointing at a check-bit position leaves the data untouched.
        for (int i = 0; i < LANE_WIDTH; i++) begin
            if (par_err && syn == edc_pos(i)) dec_data_o[i] = ~dec_data_i[i];
        end
        dec_corr_o   = par_err;
        dec_uncorr_o = !par_err && (syn != 6'd0);
    end

endmodule

// File: rtl/edc_mem_ctrl.sv
// Wishbone SEC-DED memory controller: registered reads, lane RMW, corrected writeback,
// error counters with sticky first-failure address, and test-only error injection.
module edc_mem_ctrl
    import edc_pkg::*;
#(
    parameter int WB_DWIDTH  = 128,
    parameter int WB_SWIDTH  = 16,
    parameter int ADDR_WIDTH = 12,
    parameter int WRITEBACK  = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [31:0]          i_wb_adr,
    input  logic [WB_SWIDTH-1:0] i_wb_sel,
    input  logic                 i_wb_we,
    input  logic [WB_DWIDTH-1:0] i_wb_dat,
    output logic [WB_DWIDTH-1:0] o_wb_dat,
    input  logic                 i_wb_cyc,
    input  logic                 i_wb_stb,
    output logic                 o_wb_ack,
    output logic                 o_wb_err,
    output logic [15:0]          o_corr_cnt,
    output logic                 o_uncorr,
    output logic [31:0]          o_err_adr,
    input  logic                 i_err_clr,
    input  logic                 i_inj_en,
    input  logic [WB_DWIDTH-1:0] i_inj_mask
);

    localparam int LANES   = WB_DWIDTH / LANE_WIDTH;
    localparam int SEL_LSB = $clog2(WB_SWIDTH);
    localparam int DEPTH   = 2 ** ADDR_WIDTH;
    localparam int CHK_W   = LANES * ECC_WIDTH;

    logic [WB_DWIDTH-1:0] mem_dat [DEPTH];
    logic [CHK_W-1:0]     mem_chk [DEPTH];
    logic [WB_DWIDTH-1:0] rd_dat_q;
    logic [CHK_W-1:0]     rd_chk_q;

    logic [2:0]           state_q, state_d;
    logic [31:0]          adr_q, adr_d;
    logic                 we_q, we_d;
    logic [WB_DWIDTH-1:0] dat_q, dat_d;
    logic [LANES-1:0]     lane_corr_q, lane_corr_d;
    logic [LANES-1:0]     lane_unc_q, lane_unc_d;
    logic [15:0]          cnt_q, cnt_d;
    logic                 uncorr_q, uncorr_d;
    logic [31:0]          err_adr_q, err_adr_d;

    logic                  req;
    logic [ADDR_WIDTH-1:0] idx_in, idx_q;
    logic [LANES-1:0]      lane_any, lane_part;
    logic [WB_DWIDTH-1:0]  merged;
    logic [WB_DWIDTH-1:0]  dec_dat;
    logic [LANES-1:0]      dec_corr, dec_unc;
    logic [LANES-1:0]      wr_lanes;
    logic [ADDR_WIDTH-1:0] wr_idx;
    logic [WB_DWIDTH-1:0]  wr_clean, wr_stored;
    logic [CHK_W-1:0]      wr_chk;
    logic                  wr_inj;
    logic [16:0]           ncorr, cnt_sum;

    assign req    = i_wb_cyc && i_wb_stb;
    assign idx_in = i_wb_adr[ADDR_WIDTH+SEL_LSB-1:SEL_LSB];
    assign idx_q  = adr_q[ADDR_WIDTH+SEL_LSB-1:SEL_LSB];

    always_comb begin
        lane_any  = '0;
        lane_part = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_any[l]  = |i_wb_sel[l*LANE_BYTES +: LANE_BYTES];
            lane_part[l] = lane_any[l] && !(&i_wb_sel[l*LANE_BYTES +: LANE_BYTES]);
        end
        merged = dat_q;
        for (int b = 0; b < WB_SWIDTH; b++) begin
            if (i_wb_sel[b]) merged[b*8 +: 8] = i_wb_dat[b*8 +: 8];
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        edc_lane u_lane (
            .enc_data_i   (wr_clean[l*LANE_WIDTH +: LANE_WIDTH]),
            .enc_chk_o    (wr_chk[l*ECC_WIDTH +: ECC_WIDTH]),
            .dec_data_i   (rd_dat_q[l*LANE_WIDTH +: LANE_WIDTH]),
            .dec_chk_i    (rd_chk_q[l*ECC_WIDTH +: ECC_WIDTH]),
            .dec_data_o   (dec_dat[l*LANE_WIDTH +: LANE_WIDTH]),
            .dec_corr_o   (dec_corr[l]),
            .dec_uncorr_o (dec_unc[l])
        );
    end

    // Single array write port shared by full writes, RMW commits and corrected writeback.
    // ECC is always computed on clean data; injection only disturbs the stored data.
    always_comb begin
        wr_lanes = '0;
        wr_idx   = idx_q;
        wr_clean = dat_q;
        wr_inj   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req && i_wb_we && !(|lane_part)) begin
                    wr_lanes = lane_any;
                    wr_idx   = idx_in;
                    wr_clean = i_wb_dat;
                    wr_inj   = i_inj_en;
                end
            end
            ST_RESP: begin
                if (WRITEBACK != 0 && (|lane_corr_q) && !(|lane_unc_q)) wr_lanes = lane_corr_q;
            end
            ST_MERGE: begin
                if (!(|(lane_part & lane_unc_q))) begin
                    wr_lanes = lane_any;
                    wr_clean = merged;
                    wr_inj   = i_inj_en;
                end
            end
            default: ;
        endcase
        wr_stored = wr_clean ^ (wr_inj ? i_inj_mask : '0);
    end

    // NOTE: the arrays and their read register carry no reset; zero-filled storage is already ECC-consistent.
    always_ff @(posedge i_clk) begin
        for (int l = 0; l < LANES; l++) begin
            if (wr_lanes[l]) begin
                mem_dat[wr_idx][l*LANE_WIDTH +: LANE_WIDTH] <= wr_stored[l*LANE_WIDTH +: LANE_WIDTH];
                mem_chk[wr_idx][l*ECC_WIDTH +: ECC_WIDTH]   <= wr_chk[l*ECC_WIDTH +: ECC_WIDTH];
            end
        end
        if (state_q == ST_IDLE && req) begin
            rd_dat_q <= mem_dat[idx_in];
            rd_chk_q <= mem_chk[idx_in];
        end
    end

    always_comb begin
        state_d     = state_q;
        adr_d       = adr_q;
        we_d        = we_q;
        dat_d       = dat_q;
        lane_corr_d = lane_corr_q;
        lane_unc_d  = lane_unc_q;
        cnt_d       = i_err_clr ? 16'd0 : cnt_q;
        uncorr_d    = i_err_clr ? 1'b0 : uncorr_q;
        err_adr_d   = i_err_clr ? 32'd0 : err_adr_q;
        ncorr       = '0;
        for (int l = 0; l < LANES; l++) ncorr += 17'(dec_corr[l]);
        cnt_sum = {1'b0, cnt_d} + ncorr;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    adr_d   = i_wb_adr;
                    we_d    = i_wb_we;
                    state_d = (i_wb_we && !(|lane_part)) ? ST_WACK : ST_READ;
                end
            end
            ST_READ: begin
                if (!i_wb_cyc) begin
                    state_d = ST_IDLE;
                end else begin
                    dat_d       = dec_dat;
                    lane_corr_d = dec_corr;
                    lane_unc_d  = dec_unc;
                    cnt_d       = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
                    // Clear is applied above, so an event on the same edge starts a fresh record.
                    if ((|dec_unc) && !uncorr_d) begin
                        uncorr_d  = 1'b1;
                        err_adr_d = adr_q;
                    end
                    state_d = we_q ? ST_MERGE : ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            adr_q       <= '0;
            we_q        <= 1'b0;
            dat_q       <= '0;
            lane_corr_q <= '0;
            lane_unc_q  <= '0;
            cnt_q       <= '0;
            uncorr_q    <= 1'b0;
            err_adr_q   <= '0;
        end else begin
            state_q     <= state_d;
            adr_q       <= adr_d;
            we_q        <= we_d;
            dat_q       <= dat_d;
            lane_corr_q <= lane_corr_d;
            lane_unc_q  <= lane_unc_d;
            cnt_q       <= cnt_d;
            uncorr_q    <= uncorr_d;
            err_adr_q   <= err_adr_d;
        end
    end

    assign o_wb_dat   = dat_q;
    assign o_wb_ack   = (state_q == ST_WACK) || (state_q == ST_RESP) || (state_q == ST_MERGE);
    assign o_wb_err   = ((state_q == ST_RESP) && (|lane_unc_q)) ||
                        ((state_q == ST_MERGE) && (|(lane_part & lane_unc_q)));
    assign o_corr_cnt = cnt_q;
    assign o_uncorr   = uncorr_q;
    assign o_err_adr  = err_adr_q;

endmodule

// File: tb/tb_edc_mem_ctrl.sv
// Self-checking bench for edc_mem_ctrl: the model tracks clean data plus injected bit-flips per word
// and derives expected corrections, errors and counters from the number of flips in each lane.
module tb_edc_mem_ctrl;

    localparam int W     = 128;
    localparam int S     = 16;
    localparam int LANES = 4;

    logic          clk;
    logic          rst_n;
    logic [31:0]   wb_adr;
    logic [S-1:0]  wb_sel;
    logic          wb_we;
    logic [W-1:0]  wb_dat_w;
    logic [W-1:0]  wb_dat_r;
    logic          wb_cyc;
    logic          wb_stb;
    logic          wb_ack;
    logic          wb_err;
    logic [15:0]   corr_cnt;
    logic          uncorr;
    logic [31:0]   err_adr;
    logic          err_clr;
    logic          inj_en;
    logic [W-1:0]  inj_mask;

    edc_mem_ctrl #(
        .WB_DWIDTH  (W),
        .WB_SWIDTH  (S),
        .ADDR_WIDTH (12),
        .WRITEBACK  (1)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_wb_adr   (wb_adr),
        .i_wb_sel   (wb_sel),
        .i_wb_we    (wb_we),
        .i_wb_dat   (wb_dat_w),
        .o_wb_dat   (wb_dat_r),
        .i_wb_cyc   (wb_cyc),
        .i_wb_stb   (wb_stb),
        .o_wb_ack   (wb_ack),
        .o_wb_err   (wb_err),
        .o_corr_cnt (corr_cnt),
        .o_uncorr   (uncorr),
        .o_err_adr  (err_adr),
        .i_err_clr  (err_clr),
        .i_inj_en   (inj_en),
        .i_inj_mask (inj_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: clean contents and the flipped bits actually stored, per word.
    logic [W-1:0] m_clean [int];
    logic [W-1:0] m_flip  [int];
    logic [15:0]  m_cnt;
    logic         m_unc;
    logic [31:0]  m_eadr;

    logic         exp_ack, exp_err, exp_rd;
    logic [W-1:0] exp_dat;
    logic         chk_en;
    logic         last_err;
    int           n_tests;
    int           n_fail;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("ack", wb_ack, exp_ack);
            if (exp_ack) check("err", wb_err, exp_err);
            if (exp_ack && exp_rd) check("rdata", wb_dat_r, exp_dat);
            check("corr_cnt", corr_cnt, m_cnt);
            check("uncorr", uncorr, m_unc);
            check("err_adr", err_adr, m_eadr);
        end
    end

    function automatic int word_of(input logic [31:0] adr);
        return int'((adr >> 4) & 32'hFFF);
    endfunction

    function automatic logic [W-1:0] get_or_zero(input logic [W-1:0] arr [int], input int w);
        if (arr.exists(w)) return arr[w];
        return '0;
    endfunction

    // Expected decode: 1 flipped bit in a lane is corrected, 2 are detected and returned raw.
    task automatic model_read(input int w, output logic [W-1:0] rd,
                              output logic [LANES-1:0] corr, output logic [LANES-1:0] unc);
        logic [W-1:0] clean, flip;
        int n;
        clean = get_or_zero(m_clean, w);
        flip  = get_or_zero(m_flip, w);
        rd    = clean;
        for (int l = 0; l < LANES; l++) begin
            n       = $countones(flip[l*32 +: 32]);
            corr[l] = (n == 1);
            unc[l]  = (n == 2);
            if (n == 2) rd[l*32 +: 32] = clean[l*32 +: 32] ^ flip[l*32 +: 32];
        end
    endtask

    task automatic model_store_lane(input int w, input int l, input logic [31:0] val, input logic [31:0] flip);
        logic [W-1:0] c, f;
        c = get_or_zero(m_clean, w);
        f = get_or_zero(m_flip, w);
        c[l*32 +: 32] = val;
        f[l*32 +: 32] = flip;
        m_clean[w] = c;
        m_flip[w]  = f;
    endtask

    task automatic access(input logic [31:0] adr, input logic [S-1:0] sel, input logic we,
                          input logic [W-1:0] dat, input logic inj, input logic [W-1:0] mask,
                          input logic clr_in_read, input logic drop_in_read);
        int               w, s;
        logic [LANES-1:0] any, part, corr, unc;
        logic [W-1:0]     rd, merged;
        w = word_of(adr);
        for (int l = 0; l < LANES; l++) begin
            any[l]  = (sel[l*4 +: 4] != 4'h0);
            part[l] = any[l] && (sel[l*4 +: 4] != 4'hF);
        end
        wb_adr = adr; wb_sel = sel; wb_we = we; wb_dat_w = dat;
        inj_en = inj; inj_mask = mask; wb_cyc = 1'b1; wb_stb = 1'b1;
        exp_ack = 1'b0; exp_rd = 1'b0;
        @(posedge clk); #1;
        if (we && part == '0) begin
            for (int l = 0; l < LANES; l++)
                if (any[l]) model_store_lane(w, l, dat[l*32 +: 32], inj ? mask[l*32 +: 32] : 32'h0);
            exp_ack = 1'b1; exp_err = 1'b0;
        end else begin
            err_clr = clr_in_read;
            if (drop_in_read) begin wb_cyc = 1'b0; wb_stb = 1'b0; end
            @(posedge clk); #1;
            err_clr = 1'b0;
            if (clr_in_read) begin m_cnt = '0; m_unc = 1'b0; m_eadr = '0; end
            if (!drop_in_read) begin
                model_read(w, rd, corr, unc);
                s = int'(m_cnt) + $countones(corr);
                m_cnt = (s > 65535) ? 16'hFFFF : 16'(s);
                if ((|unc) && !m_unc) begin m_unc = 1'b1; m_eadr = adr; end
                exp_ack = 1'b1;
                if (!we) begin
                    exp_rd = 1'b1; exp_dat = rd; exp_err = |unc;
                    if ((|corr) && !(|unc))
                        for (int l = 0; l < LANES; l++)
                            if (corr[l]) model_store_lane(w, l, rd[l*32 +: 32], 32'h0);
                end else begin
                    exp_err = |(part & unc);
                    merged = rd;
                    for (int b = 0; b < S; b++) if (sel[b]) merged[b*8 +: 8] = dat[b*8 +: 8];
                    if (!exp_err)
                        for (int l = 0; l < LANES; l++)
                            if (any[l]) model_store_lane(w, l, merged[l*32 +: 32], inj ? mask[l*32 +: 32] : 32'h0);
                end
            end
        end
        @(negedge clk);
        last_err = wb_err;
        @(posedge clk); #1;
        wb_cyc = 1'b0; wb_stb = 1'b0; inj_en = 1'b0;
        exp_ack = 1'b0; exp_rd = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wr_full(input logic [31:0] adr, input logic [W-1:0] dat, input logic [W-1:0] mask);
        access(adr, 16'hFFFF, 1'b1, dat, mask != '0, mask, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic [31:0] adr, input logic clr);
        access(adr, 16'hFFFF, 1'b0, '0, 1'b0, '0, clr, 1'b0);
    endtask

    task automatic clear_errs();
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        m_cnt = '0; m_unc = 1'b0; m_eadr = '0;
    endtask

    function automatic logic [W-1:0] gen_mask();
        logic [W-1:0] m;
        int k, b0, b1;
        m = '0;
        for (int l = 0; l < LANES; l++) begin
            k  = $urandom_range(0, 4);
            b0 = $urandom_range(0, 31);
            b1 = (b0 + $urandom_range(1, 31)) % 32;
            if (k >= 3) m[l*32 + b0] = 1'b1;
            if (k == 4) m[l*32 + b1] = 1'b1;
        end
        return m;
    endfunction

    localparam logic [W-1:0] D1 = 128'h0123456789ABCDEF0123456789ABCDEF;

    initial begin
        logic [W-1:0] m, d;
        logic [S-1:0] sel;
        int op;
        n_tests = 0; n_fail = 0; chk_en = 1'b0;
        wb_adr = '0; wb_sel = '0; wb_we = 1'b0; wb_dat_w = '0; wb_cyc = 1'b0; wb_stb = 1'b0;
        err_clr = 1'b0; inj_en = 1'b0; inj_mask = '0;
        m_cnt = '0; m_unc = 1'b0; m_eadr = '0; exp_ack = 1'b0; exp_err = 1'b0; exp_rd = 1'b0; exp_dat = '0;
        last_err = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #20;
        check("rst_ack", wb_ack, 1'b0);
        check("rst_dat", wb_dat_r, '0);
        check("rst_err_adr", err_adr, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Clean full write then read.
        wr_full(32'h40, D1, '0);
        rd(32'h40, 1'b0);
        check("pin_clean_data", wb_dat_r, D1);
        check("pin_clean_cnt", corr_cnt, 16'd0);

        // Single-bit injection is corrected; writeback keeps a second read clean.
        m = '0; m[5] = 1'b1;
        wr_full(32'h40, D1, m);
        rd(32'h40, 1'b0);
        check("pin_corr_data", wb_dat_r, D1);
        check("pin_corr_cnt", corr_cnt, 16'd1);
        rd(32'h40, 1'b0);
        check("pin_wb_cnt", corr_cnt, 16'd1);

        // Double-bit error in lane 2; the first failing address is retained.
        m = '0; m[67] = 1'b1; m[73] = 1'b1;
        wr_full(32'h40, D1, m);
        rd(32'h40, 1'b0);
        check("pin_dbl_err", last_err, 1'b1);
        check("pin_dbl_sticky", uncorr, 1'b1);
        check("pin_dbl_adr", err_adr, 32'h40);
        wr_full(32'h80, D1, m);
        rd(32'h80, 1'b0);
        check("pin_first_adr", err_adr, 32'h40);
        clear_errs();

        // Partial-lane RMW.
        wr_full(32'h100, {96'h0, 32'h11223344}, '0);
        access(32'h100, 16'h0003, 1'b1, {112'h0, 16'hBEEF}, 1'b0, '0, 1'b0, 1'b0);
        rd(32'h100, 1'b0);
        d = wb_dat_r;
        check("pin_rmw_lane0", d[31:0], 32'h1122BEEF);

        // Partial write into a lane holding a double error is refused.
        m = '0; m[33] = 1'b1; m[40] = 1'b1;
        wr_full(32'hC0, D1, m);
        access(32'hC0, 16'h0010, 1'b1, {W{1'b1}}, 1'b0, '0, 1'b0, 1'b0);
        check("pin_rmw_abort", last_err, 1'b1);
        rd(32'hC0, 1'b0);
        clear_errs();

        // Reset while the controller is in the read cycle.
        m = '0; m[100] = 1'b1;
        wr_full(32'h180, D1, m);
        wb_adr = 32'h180; wb_sel = 16'hFFFF; wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        wb_cyc = 1'b0; wb_stb = 1'b0;
        m_cnt = '0; m_unc = 1'b0; m_eadr = '0;
        #2;
        check("rst_mid_ack", wb_ack, 1'b0);
        check("rst_mid_dat", wb_dat_r, '0);
        check("rst_mid_cnt", corr_cnt, 16'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Clear coincident with a correctable read.
        m = '0; m[1] = 1'b1; m[40] = 1'b1; m[99] = 1'b1;
        wr_full(32'h1C0, D1, m);
        rd(32'h1C0, 1'b0);
        m = '0; m[7] = 1'b1;
        wr_full(32'h140, D1, m);
        rd(32'h140, 1'b1);
        check("pin_clr_corr", corr_cnt, 16'd1);

        // Abandoned read: no ack, no counting.
        wr_full(32'h200, D1, m);
        access(32'h200, 16'hFFFF, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);

        // Randomised traffic over eight words with aliased upper address bits.
        for (int i = 0; i < 8; i++) wr_full(32'(i << 4), {$urandom, $urandom, $urandom, $urandom}, '0);
        for (int i = 0; i < 400; i++) begin
            wb_adr = ($urandom << 16) | 32'($urandom_range(0, 7) << 4) | 32'($urandom_range(0, 15));
            d  = {$urandom, $urandom, $urandom, $urandom};
            op = $urandom_range(0, 9);
            if (op < 4) begin
                access(wb_adr, 16'hFFFF, 1'b0, '0, 1'b0, '0, $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
            end else if (op < 7) begin
                for (int l = 0; l < LANES; l++) sel[l*4 +: 4] = ($urandom_range(0, 3) != 0) ? 4'hF : 4'h0;
                m = gen_mask();
                access(wb_adr, sel, 1'b1, d, m != '0, m, 1'b0, 1'b0);
            end else if (op < 9) begin
                sel = S'($urandom_range(1, 16'hFFFF));
                access(wb_adr, sel, 1'b1, d, 1'b0, '0, $urandom_range(0, 9) == 0, 1'b0);
            end else begin
                clear_errs();
            end
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
